q_seg_display: RTL and testbench

- Downstream stage of the up/down counter in the top level.
- Takes the counter's 5-bit output Q (0..31), which is produced in the divided-clock domain.
- Resynchronises and filters Q into CLK50MHz, converts it to two decimal digits, and drives a time-multiplexed, active-low 4-digit 7-segment display.
- Only the two rightmost digits are used; the tens digit has leading-zero blanking, and a short anode blanking gap between slots suppresses ghosting.

---
 rtl/q_seg_display_if.sv | 10 +
 rtl/q_seg_display.sv | 100 ++++++++++
 tb/tb_q_seg_display.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_seg_display_if.sv
// rtl/q_seg_display_if.sv - counter value in, multiplexed 7-segment drive out
interface q_seg_display_if;
  logic [4:0] Q_IN;
  logic [6:0] SEG;
  logic       DP;
  logic [3:0] AN;

  modport master (output Q_IN, input SEG, DP, AN);
  modport slave  (input Q_IN, output SEG, DP, AN);
endinterface

// File: rtl/q_seg_display.sv
// rtl/q_seg_display.sv - resync/filter counter value, show as two multiplexed
// decimal digits with leading-zero and inter-slot anode blanking
module q_seg_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic            CLK50MHz,
  input  logic            RST,
  q_seg_display_if.slave  disp
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [4:0]    s1_q, s2_q, s3_q, stable_q, frame_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          load;
  logic [1:0]    tens;
  logic [4:0]    ones;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  function automatic logic [6:0] seg_code(input logic [4:0] d);
    case (d)
      5'd0:    seg_code = 7'b1000000;
      5'd1:    seg_code = 7'b1111001;
      5'd2:    seg_code = 7'b0100100;
      5'd3:    seg_code = 7'b0110000;
      5'd4:    seg_code = 7'b0011001;
      5'd5:    seg_code = 7'b0010010;
      5'd6:    seg_code = 7'b0000010;
      5'd7:    seg_code = 7'b1111000;
      5'd8:    seg_code = 7'b0000000;
      5'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    tens = 2'd0;
    ones = frame_q;
    if (frame_q >= 5'd30) begin
      tens = 2'd3;
      ones = frame_q - 5'd30;
    end else if (frame_q >= 5'd20) begin
      tens = 2'd2;
      ones = frame_q - 5'd20;
    end else if (frame_q >= 5'd10) begin
      tens = 2'd1;
      ones = frame_q - 5'd10;
    end
  end

  // Frame latch loads on the tens->ones wrap, so both digits share one value.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    sel_d = (cnt_q == LAST) ? ~sel_q : sel_q;
    load  = (cnt_q == LAST) && sel_q;
    if (sel_q)
      seg_d = (tens == 2'd0) ? 7'b1111111 : seg_code({3'd0, tens});
    else
      seg_d = seg_code(ones);
    if (cnt_q < BLANK_END)
      an_d = 4'b1111;
    else
      an_d = sel_q ? 4'b1101 : 4'b1110;
  end

  always_ff @(posedge CLK50MHz) begin
    if (RST) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      stable_q <= '0;
      frame_q  <= '0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      seg_q    <= 7'b1111111;
      an_q     <= 4'b1111;
    end else begin
      s1_q <= disp.Q_IN;
      s2_q <= s1_q;
      s3_q <= s2_q;
      // Two equal consecutive samples required; a one-clock glitch never matches.
      if (s2_q == s3_q)
        stable_q <= s2_q;
      if (load)
        frame_q <= stable_q;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign disp.SEG = seg_q;
  assign disp.AN  = an_q;
  assign disp.DP  = 1'b1;
endmodule

// File: tb/tb_q_seg_display.sv
// tb/tb_q_seg_display.sv - directed self-checking bench for q_seg_display
module tb_q_seg_display;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n = 0;
  int   checks = 0;
  int   failures = 0;

  q_seg_display_if dif ();

  q_seg_display #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .CLK50MHz (clk),
    .RST      (rst),
    .disp     (dif)
  );

  always #5 clk = ~clk;

  // Edge n after release shows state k=(n-1)%16: ones slot k<8, blank k in {0,1,8,9}.
  task automatic tick;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic go(input int target);
    while (n < target) tick();
  endtask

  task automatic do_reset(input logic [4:0] v);
    rst = 1'b1;
    dif.Q_IN = v;
    repeat (3) tick();
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dif.Q_IN = 5'd17;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dif.SEG !== 7'b1111111 || dif.AN !== 4'b1111 || dif.DP !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold seg=%b an=%b dp=%b required seg=1111111 an=1111 dp=1", dif.SEG, dif.AN, dif.DP);
      end
    end
    rst = 1'b0;
    n = 0;
    go(1);
    checks++;
    if (dif.AN !== 4'b1111) begin
      failures++;
      $display("FAIL reset_first_blank an=%b required 1111", dif.AN);
    end
    go(3);
    checks++;
    if (dif.AN !== 4'b1110 || dif.SEG !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_frame0_ones an=%b seg=%b required an=1110 seg=1000000", dif.AN, dif.SEG);
    end
    go(11);
    checks++;
    if (dif.AN !== 4'b1101 || dif.SEG !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_frame0_tens an=%b seg=%b required an=1101 seg=1111111", dif.AN, dif.SEG);
    end
    go(19);
    checks++;
    if (dif.AN !== 4'b1110 || dif.SEG !== 7'b1111000) begin
      failures++;
      $display("FAIL reset_ones7 an=%b seg=%b required an=1110 seg=1111000", dif.AN, dif.SEG);
    end
    go(27);
    checks++;
    if (dif.AN !== 4'b1101 || dif.SEG !== 7'b1111001) begin
      failures++;
      $display("FAIL reset_tens1 an=%b seg=%b required an=1101 seg=1111001", dif.AN, dif.SEG);
    end
  endtask

  task automatic test_slot_timing;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int k;
    do_reset(5'd23);
    for (int e = 1; e <= 48; e++) begin
      go(e);
      k = (e - 1) % 16;
      if (k < 2 || (k >= 8 && k < 10)) exp_an = 4'b1111;
      else if (k < 8)                  exp_an = 4'b1110;
      else                             exp_an = 4'b1101;
      checks++;
      if (dif.AN !== exp_an) begin
        failures++;
        $display("FAIL slot_an edge=%0d an=%b required %b", e, dif.AN, exp_an);
      end
      if (e > 16 && exp_an != 4'b1111) begin
        exp_seg = (k < 8) ? 7'b0110000 : 7'b0100100;
        checks++;
        if (dif.SEG !== exp_seg) begin
          failures++;
          $display("FAIL slot_seg edge=%0d seg=%b required %b", e, dif.SEG, exp_seg);
        end
      end
    end
  endtask

  task automatic test_leading_zero;
    do_reset(5'd4);
    go(19);
    checks++;
    if (dif.AN !== 4'b1110 || dif.SEG !== 7'b0011001) begin
      failures++;
      $display("FAIL lz4_ones an=%b seg=%b required an=1110 seg=0011001", dif.AN, dif.SEG);
    end
    go(27);
    checks++;
    if (dif.AN !== 4'b1101 || dif.SEG !== 7'b1111111) begin
      failures++;
      $display("FAIL lz4_tens an=%b seg=%b required an=1101 seg=1111111", dif.AN, dif.SEG);
    end
    dif.Q_IN = 5'd0;
    go(35);
    checks++;
    if (dif.AN !== 4'b1110 || dif.SEG !== 7'b1000000) begin
      failures++;
      $display("FAIL lz0_ones an=%b seg=%b required an=1110 seg=1000000", dif.AN, dif.SEG);
    end
    go(43);
    checks++;
    if (dif.AN !== 4'b1101 || dif.SEG !== 7'b1111111) begin
      failures++;
      $display("FAIL lz0_tens an=%b seg=%b required an=1101 seg=1111111", dif.AN, dif.SEG);
    end
  endtask

  task automatic test_glitch;
    logic [6:0] exp_seg;
    int k;
    do_reset(5'd12);
    for (int e = 17; e <= 64; e++) begin
      go(e);
      if (e == 20) dif.Q_IN = 5'd31;
      if (e == 21) dif.Q_IN = 5'd12;
      k = (e - 1) % 16;
      if ((k >= 2 && k < 8) || k >= 10) begin
        exp_seg = (k < 8) ? 7'b0100100 : 7'b1111001;
        checks++;
        if (dif.SEG !== exp_seg) begin
          failures++;
          $display("FAIL glitch edge=%0d seg=%b required %b", e, dif.SEG, exp_seg);
        end
      end
    end
  endtask

  task automatic test_tear_free;
    do_reset(5'd9);
    go(25);
    dif.Q_IN = 5'd10;
    go(30);
    checks++;
    if (dif.AN !== 4'b1101 || dif.SEG !== 7'b1111111) begin
      failures++;
      $display("FAIL tear_cur_tens an=%b seg=%b required an=1101 seg=1111111", dif.AN, dif.SEG);
    end
    go(35);
    checks++;
    if (dif.AN !== 4'b1110 || dif.SEG !== 7'b1000000) begin
      failures++;
      $display("FAIL tear_next_ones an=%b seg=%b required an=1110 seg=1000000", dif.AN, dif.SEG);
    end
    go(43);
    checks++;
    if (dif.AN !== 4'b1101 || dif.SEG !== 7'b1111001) begin
      failures++;
      $display("FAIL tear_next_tens an=%b seg=%b required an=1101 seg=1111001", dif.AN, dif.SEG);
    end
  endtask

  // Q change after edge 28 reaches the stable value on edge 32, the frame load edge.
  task automatic test_simultaneous;
    do_reset(5'd9);
    go(28);
    dif.Q_IN = 5'd10;
    go(35);
    checks++;
    if (dif.SEG !== 7'b0010000) begin
      failures++;
      $display("FAIL simul_old_ones seg=%b required 0010000", dif.SEG);
    end
    go(43);
    checks++;
    if (dif.SEG !== 7'b1111111) begin
      failures++;
      $display("FAIL simul_old_tens seg=%b required 1111111", dif.SEG);
    end
    go(51);
    checks++;
    if (dif.SEG !== 7'b1000000) begin
      failures++;
      $display("FAIL simul_new_ones seg=%b required 1000000", dif.SEG);
    end
    go(59);
    checks++;
    if (dif.SEG !== 7'b1111001) begin
      failures++;
      $display("FAIL simul_new_tens seg=%b required 1111001", dif.SEG);
    end
  endtask

  task automatic test_boundaries;
    logic [4:0] vals [4];
    logic [6:0] exp_ones [4];
    logic [6:0] exp_tens [4];
    vals[0] = 5'd29; exp_ones[0] = 7'b0010000; exp_tens[0] = 7'b0100100;
    vals[1] = 5'd30; exp_ones[1] = 7'b1000000; exp_tens[1] = 7'b0110000;
    vals[2] = 5'd31; exp_ones[2] = 7'b1111001; exp_tens[2] = 7'b0110000;
    vals[3] = 5'd0;  exp_ones[3] = 7'b1000000; exp_tens[3] = 7'b1111111;
    do_reset(vals[0]);
    for (int f = 1; f <= 4; f++) begin
      go(16 * f + 4);
      if (f < 4) dif.Q_IN = vals[f];
      go(16 * f + 5);
      checks++;
      if (dif.AN !== 4'b1110 || dif.SEG !== exp_ones[f-1]) begin
        failures++;
        $display("FAIL bound_ones v=%0d an=%b seg=%b required an=1110 seg=%b", vals[f-1], dif.AN, dif.SEG, exp_ones[f-1]);
      end
      go(16 * f + 13);
      checks++;
      if (dif.AN !== 4'b1101 || dif.SEG !== exp_tens[f-1]) begin
        failures++;
        $display("FAIL bound_tens v=%0d an=%b seg=%b required an=1101 seg=%b", vals[f-1], dif.AN, dif.SEG, exp_tens[f-1]);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (dif.AN !== 4'b1111 || dif.SEG !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_mid_drive an=%b seg=%b required an=1111 seg=1111111", dif.AN, dif.SEG);
    end
    rst = 1'b0;
  endtask

  initial begin
    dif.Q_IN = 5'd0;
    test_reset();
    test_slot_timing();
    test_leading_zero();
    test_glitch();
    test_tear_free();
    test_simultaneous();
    test_boundaries();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
